sm_clk_ctrl: RTL and testbench

//  Multi-channel clock-enable controller replacing the fixed 2^n clock divider for board bring-up.

---
 rtl/sm_clk_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sm_clk_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_clk_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// sm_clk_ctrl : multi-channel STOP/RUN/STEP/BURST clock-enable controller
// Rev 1.0
// ------------------------------------------------------------------------
module sm_clk_ctrl #(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = 32,
    parameter int SHIFT       = 16,
    parameter int DIV_W       = 4,
    parameter int STEP_STABLE = 1024,
    parameter int BURST_LEN   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*CHANNELS-1:0]     mode_i,
    input  logic [DIV_W*CHANNELS-1:0] devide_i,
    input  logic                      step_i,
    output logic [CHANNELS-1:0]       tick_o,
    output logic [CHANNELS-1:0]       busy_o
);
    localparam int STAB_W = $clog2(STEP_STABLE + 1);
    localparam int BCNT_W = $clog2(BURST_LEN + 1);
    localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(STEP_STABLE - 1);
    localparam logic [BCNT_W-1:0] BURST_INIT = BCNT_W'(BURST_LEN);

    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic {
        BS_IDLE = 1'b0,
        BS_BUSY = 1'b1
    } burst_state_t;

    // Sets the low e bits, e = SHIFT+dv; bits at or above CNT_W are never set,
    // which gives the clamp to an all-ones reload without any wrapping shift.
    function automatic logic [CNT_W-1:0] reload_of(input logic [DIV_W-1:0] dv);
        int               e;
        logic [CNT_W-1:0] r;
        e = SHIFT + int'(dv);
        r = '0;
        for (int b = 0; b < CNT_W; b++) begin
            if (b < e) r[b] = 1'b1;
        end
        return r;
    endfunction

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              level_q, level_d;
    logic              level_dly_q, level_dly_d;
    logic              press_q, press_d;
    logic [STAB_W-1:0] stab_q, stab_d;

    always_comb begin
        sync1_d     = step_i;
        sync2_d     = sync1_q;
        level_d     = level_q;
        stab_d      = '0;
        level_dly_d = level_q;
        press_d     = level_q & ~level_dly_q;
        if (sync2_q != level_q) begin
            if (stab_q == STAB_LAST) begin
                level_d = sync2_q;
            end else begin
                stab_d = stab_q + STAB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            stab_q      <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            stab_q      <= stab_d;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [1:0]        mode;
        logic [DIV_W-1:0]  dev;
        logic [CNT_W-1:0]  reload;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [BCNT_W-1:0] bcnt_q, bcnt_d;
        burst_state_t      state_q, state_d;
        logic              tick_q, tick_d;

        assign mode   = mode_i[2*ch +: 2];
        assign dev    = devide_i[DIV_W*ch +: DIV_W];
        assign reload = reload_of(dev);

        // Every path not actively counting reloads, so leaving RUN or BURST drops the residue.
        always_comb begin
            cnt_d   = reload;
            bcnt_d  = bcnt_q;
            state_d = BS_IDLE;
            tick_d  = 1'b0;
            case (mode)
                MODE_STOP: begin
                end
                MODE_RUN: begin
                    if (cnt_q == '0) begin
                        tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                MODE_STEP: begin
                    tick_d = press_q;
                end
                MODE_BURST: begin
                    case (state_q)
                        BS_IDLE: begin
                            if (press_q) begin
                                state_d = BS_BUSY;
                                bcnt_d  = BURST_INIT;
                            end
                        end
                        BS_BUSY: begin
                            state_d = BS_BUSY;
                            if (bcnt_q == '0) begin
                                state_d = BS_IDLE;
                            end else if (cnt_q == '0) begin
                                tick_d = 1'b1;
                                bcnt_d = bcnt_q - 1'b1;
                            end else begin
                                cnt_d = cnt_q - 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q   <= reload;
                bcnt_q  <= '0;
                state_q <= BS_IDLE;
                tick_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                bcnt_q  <= bcnt_d;
                state_q <= state_d;
                tick_q  <= tick_d;
            end
        end

        assign tick_o[ch] = tick_q;
        assign busy_o[ch] = (state_q == BS_BUSY);
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_clk_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_sm_clk_ctrl : directed + random bench for sm_clk_ctrl with reference model
// Rev 1.0
// ------------------------------------------------------------------------
module tb_sm_clk_ctrl;
    localparam int CH    = 2;
    localparam int CNT_W = 8;
    localparam int SHIFT = 2;
    localparam int DIV_W = 4;
    localparam int SS    = 4;
    localparam int BL    = 3;

    localparam logic [1:0] STOP  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] STEP  = 2'b10;
    localparam logic [1:0] BURST = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2*CH-1:0]     mode_i;
    logic [DIV_W*CH-1:0] devide_i;
    logic          step_i;
    logic [CH-1:0] tick_o;
    logic [CH-1:0] busy_o;

    sm_clk_ctrl #(
        .CHANNELS   (CH),
        .CNT_W      (CNT_W),
        .SHIFT      (SHIFT),
        .DIV_W      (DIV_W),
        .STEP_STABLE(SS),
        .BURST_LEN  (BL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode_i  (mode_i),
        .devide_i(devide_i),
        .step_i  (step_i),
        .tick_o  (tick_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mark   = 0;

    // Reference model: absolute-time deadlines for ticks, a sample window for the filter.
    int next_tick[CH];
    bit busy_m[CH];
    bit tick_m[CH];
    int brem[CH];
    bit sp1 = 1'b0, sp2 = 1'b0;
    bit level_m = 1'b0;
    bit samp[$];
    int rise_at = -100;

    int q0[$];
    int q1[$];
    int brise = -1;
    int bfall = -1;
    bit bprev = 1'b0;

    function automatic int period(int dv);
        int e;
        e = SHIFT + dv;
        if (e > CNT_W) e = CNT_W;
        return 1 << e;
    endfunction

    function automatic int dev_of(int c);
        return int'(devide_i[DIV_W*c +: DIV_W]);
    endfunction

    function automatic int qat(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_ch(int c, logic [1:0] m, logic [3:0] d);
        mode_i[2*c +: 2]         = m;
        devide_i[DIV_W*c +: DIV_W] = d;
    endtask

    task automatic model_edge();
        int         n;
        bit         press;
        bit         s;
        bit         all_diff;
        int         p;
        logic [1:0] md;
        n = cyc;
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                tick_m[c]    = 1'b0;
                busy_m[c]    = 1'b0;
                brem[c]      = 0;
                next_tick[c] = n + period(dev_of(c));
            end
            sp1 = 1'b0;
            sp2 = 1'b0;
            level_m = 1'b0;
            rise_at = -100;
            samp.delete();
        end else begin
            press = (rise_at == n - 2);
            s   = sp2;
            sp2 = sp1;
            sp1 = step_i;
            samp.push_back(s);
            if (samp.size() > SS) void'(samp.pop_front());
            if (samp.size() == SS) begin
                all_diff = 1'b1;
                foreach (samp[i]) if (samp[i] == level_m) all_diff = 1'b0;
                if (all_diff) begin
                    level_m = !level_m;
                    if (level_m) rise_at = n;
                    samp.delete();
                end
            end
            for (int c = 0; c < CH; c++) begin
                p  = period(dev_of(c));
                md = mode_i[2*c +: 2];
                tick_m[c] = 1'b0;
                case (md)
                    STOP: begin
                        next_tick[c] = n + p;
                        busy_m[c]    = 1'b0;
                    end
                    RUN: begin
                        busy_m[c] = 1'b0;
                        if (n == next_tick[c]) begin
                            tick_m[c]    = 1'b1;
                            next_tick[c] = n + p;
                        end
                    end
                    STEP: begin
                        tick_m[c]    = press;
                        next_tick[c] = n + p;
                        busy_m[c]    = 1'b0;
                    end
                    default: begin
                        if (!busy_m[c]) begin
                            next_tick[c] = n + p;
                            if (press) begin
                                busy_m[c] = 1'b1;
                                brem[c]   = BL;
                            end
                        end else if (brem[c] == 0) begin
                            busy_m[c]    = 1'b0;
                            next_tick[c] = n + p;
                        end else if (n == next_tick[c]) begin
                            tick_m[c]    = 1'b1;
                            brem[c]      = brem[c] - 1;
                            next_tick[c] = n + p;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic cycle_step();
        int rel;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        rel = cyc - mark;
        for (int c = 0; c < CH; c++) begin
            check($sformatf("ch%0d_tick@%0d", c, cyc), 32'(tick_o[c]), 32'(tick_m[c]));
            check($sformatf("ch%0d_busy@%0d", c, cyc), 32'(busy_o[c]), 32'(busy_m[c]));
        end
        if (tick_o[0] === 1'b1) q0.push_back(rel);
        if (tick_o[1] === 1'b1) q1.push_back(rel);
        if (busy_o[1] === 1'b1 && !bprev && brise < 0) brise = rel;
        if (busy_o[1] === 1'b0 && bprev) bfall = rel;
        bprev = (busy_o[1] === 1'b1);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle_step();
    endtask

    task automatic set_mark();
        mark = cyc;
        q0.delete();
        q1.delete();
        brise = -1;
        bfall = -1;
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            next_tick[c] = 0;
            busy_m[c]    = 1'b0;
            tick_m[c]    = 1'b0;
            brem[c]      = 0;
        end
        rst_n    = 1'b0;
        mode_i   = '0;
        devide_i = '0;
        step_i   = 1'b0;
        set_ch(0, RUN, 4'd0);

        // reset, then ch0 RUN period 4
        run(3);
        check("rst_tick", 32'(tick_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        set_mark();
        run(16);
        check("run4_count", q0.size(), 4);
        check("run4_first", qat(q0, 0), 4);
        check("run4_last", qat(q0, 3), 16);

        // ch1 RUN devide 3, changed to 1 mid-count
        set_ch(1, STOP, 4'd3);
        run(1);
        set_ch(1, RUN, 4'd3);
        set_mark();
        run(10);
        set_ch(1, RUN, 4'd1);
        run(46);
        check("div_first", qat(q1, 0), 32);
        check("div_second", qat(q1, 1), 40);
        check("div_third", qat(q1, 2), 48);

        // exponent clamp
        set_ch(1, STOP, 4'd15);
        run(1);
        set_ch(1, RUN, 4'd15);
        set_mark();
        run(260);
        check("clamp_count", q1.size(), 1);
        check("clamp_first", qat(q1, 0), 256);

        // STEP: short glitch, clean press, bounce on release
        set_ch(0, STEP, 4'd0);
        set_ch(1, STOP, 4'd0);
        run(2);
        set_mark();
        step_i = 1'b1; run(2);
        step_i = 1'b0; run(10);
        check("glitch_ticks", q0.size(), 0);
        set_mark();
        step_i = 1'b1; run(10);
        step_i = 1'b0; run(10);
        check("step_count", q0.size(), 1);
        check("step_latency", qat(q0, 0), 8);
        set_mark();
        step_i = 1'b1; run(10);
        step_i = 1'b0; run(3);
        step_i = 1'b1; run(10);
        step_i = 1'b0; run(10);
        check("bounce_count", q0.size(), 1);

        // BURST on ch1
        set_ch(0, STOP, 4'd0);
        set_ch(1, BURST, 4'd0);
        run(2);
        set_mark();
        step_i = 1'b1; run(8);
        step_i = 1'b0; run(20);
        check("burst_rise", brise, 8);
        check("burst_t1", qat(q1, 0), 12);
        check("burst_t2", qat(q1, 1), 16);
        check("burst_t3", qat(q1, 2), 20);
        check("burst_count", q1.size(), 3);
        check("burst_fall", bfall, 21);

        set_mark();
        step_i = 1'b1; run(5);
        step_i = 1'b0; run(4);
        step_i = 1'b1; run(12);
        step_i = 1'b0; run(12);
        check("busy_press_count", q1.size(), 3);
        check("busy_press_fall", bfall, 21);

        set_mark();
        step_i = 1'b1; run(13);
        set_ch(1, STOP, 4'd0);
        run(1);
        check("abort_busy", 32'(busy_o[1]), 32'd0);
        step_i = 1'b0; run(20);
        check("abort_ticks", q1.size(), 1);
        check("abort_fall", bfall, 14);

        // shared press, then reset mid-burst
        set_ch(0, STEP, 4'd0);
        set_ch(1, BURST, 4'd0);
        run(2);
        set_mark();
        step_i = 1'b1; run(8);
        check("shared_tick0", 32'(tick_o[0]), 32'd1);
        check("shared_busy1", 32'(busy_o[1]), 32'd1);
        check("shared_rise", brise, 8);
        run(2);
        rst_n = 1'b0; run(1);
        check("midrst_tick", 32'(tick_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        set_mark();
        run(10);
        check("requal_tick", qat(q0, 0), 8);
        step_i = 1'b0; run(20);

        // random phase
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0)
                set_ch(0, 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 2)));
            if ($urandom_range(0, 19) == 0)
                set_ch(1, 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 2)));
            if ($urandom_range(0, 5) == 0) step_i = ~step_i;
            rst_n = ($urandom_range(0, 299) != 0);
            cycle_step();
        end
        rst_n = 1'b1;
        run(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
